// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit memory between instruction fetch (IF) and load/store (DM).
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority, DM over IF.
module mem_port_arbiter #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   output logic              if_resp_valid,
   output logic [31:0]       if_resp_data,
   input  logic              dm_req_valid,
   input  logic              dm_req_wr,
   input  logic [ADDR_W-1:0] dm_req_addr,
   input  logic [63:0]       dm_req_wdata,
   input  logic [7:0]        dm_req_mask,
   output logic              dm_req_ready,
   output logic              dm_resp_valid,
   output logic [63:0]       dm_resp_data,
   output logic              ram_en,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [63:0]       ram_wdata,
   output logic [7:0]        ram_mask,
   input  logic [63:0]       ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
   typedef enum logic {OwnDm, OwnIf} owner_e;

   state_e     state_q;
   owner_e     owner_q;
   logic [2:0] lat_cnt_q;
   logic       addr2_q;
   logic       wr_q;
   logic       can_grant;
   logic       grant_if;
   logic       grant_dm;
   logic       in_resp;
   logic       unused_addr_bits;
`ifdef MEM_ARB_RR_EN
   logic       last_dm_q;
`endif

   // Byte offset within a word is the requester's concern.
   assign unused_addr_bits = ^{if_req_addr[1:0], dm_req_addr[1:0]};

   // No grant while reset is held, so nothing is accepted and then dropped.
   assign can_grant = (state_q == StIdle) && !reset;

   always_comb begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
      if (can_grant) begin
`ifdef MEM_ARB_RR_EN
         if (dm_req_valid && if_req_valid) begin
            grant_dm = !last_dm_q;
            grant_if = last_dm_q;
         end else begin
            grant_dm = dm_req_valid;
            grant_if = if_req_valid;
         end
`else
         grant_dm = dm_req_valid;
         grant_if = if_req_valid && !dm_req_valid;
`endif
      end
   end

   assign if_req_ready = grant_if;
   assign dm_req_ready = grant_dm;
   assign ram_en       = grant_if | grant_dm;
   assign ram_wr       = grant_dm & dm_req_wr;
   assign ram_addr     = grant_dm ? {dm_req_addr[ADDR_W-1:3], 3'b000} :
                         grant_if ? {if_req_addr[ADDR_W-1:3], 3'b000} : '0;
   assign ram_wdata    = ram_wr ? dm_req_wdata : '0;
   assign ram_mask     = ram_wr ? dm_req_mask : '0;
   assign busy         = (state_q != StIdle);

   assign in_resp       = (state_q == StResp) && !reset;
   assign if_resp_valid = in_resp && (owner_q == OwnIf);
   assign dm_resp_valid = in_resp && (owner_q == OwnDm);
   assign if_resp_data  = !if_resp_valid ? '0 :
                          addr2_q ? ram_rdata[63:32] : ram_rdata[31:0];
   assign dm_resp_data  = (dm_resp_valid && !wr_q) ? ram_rdata : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         lat_cnt_q <= '0;
         owner_q   <= OwnDm;
         addr2_q   <= 1'b0;
         wr_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_dm_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (ram_en) begin
                  owner_q <= grant_dm ? OwnDm : OwnIf;
                  addr2_q <= grant_dm ? dm_req_addr[2] : if_req_addr[2];
                  wr_q    <= ram_wr;
`ifdef MEM_ARB_RR_EN
                  last_dm_q <= grant_dm;
`endif
                  if (ram_wr || RD_LAT == 1) begin
                     state_q <= StResp;
                  end else begin
                     state_q   <= StWait;
                     lat_cnt_q <= 3'(RD_LAT - 1);
                  end
               end
            end
            StWait: begin
               // Leaving on the count's last step puts RESP exactly RD_LAT cycles after grant.
               lat_cnt_q <= lat_cnt_q - 3'd1;
               if (lat_cnt_q == 3'd1) begin
                  state_q <= StResp;
               end
            end
            StResp: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
